// File: rtl/serial_slice_adder_pkg.sv
// Shared types and helpers for the serial slice adder.
// Holds the controller state encoding and the slice-count helper.
package adder_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} adder_state_e;

   // Number of RUN cycles needed to cover the operand; a zero slice yields 1
   // so the caller's elaboration check can report the problem cleanly.
   function automatic int slice_count(input int width, input int slice);
      return (slice > 0) ? width / slice : 1;
   endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational SLICE-bit ripple adder built from full-adder cells.
// The top module reuses one instance for every slice of an addition.
module slice_adder #(
   parameter int SLICE = 1
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co
);

   logic [SLICE:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < SLICE; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign co = c[SLICE];

endmodule

// File: rtl/serial_slice_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed SLICE bits per clock through a carry register.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port that turns the block into A-B.
module serial_slice_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SLICE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             result_valid,
   output logic [WIDTH:0]   sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSL = slice_count(WIDTH, SLICE);
   localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSL - 1);

   if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("serial_slice_adder: WIDTH=%0d must be a positive multiple of SLICE=%0d",
             WIDTH, SLICE);
   end

   // Effective B operand and carry-in; subtraction is A + ~B + 1.
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
`ifdef SERIAL_ADDER_SUB_EN
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub ? 1'b1 : cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   adder_state_e     state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [SLICE-1:0] x_sl, y_sl, s_sl;
   logic             co_sl;
   int               lo;

   always_comb begin
      lo   = int'(cnt) * SLICE;
      x_sl = a_r[lo +: SLICE];
      y_sl = b_r[lo +: SLICE];
   end

   slice_adder #(.SLICE(SLICE)) u_slice (
      .x  (x_sl),
      .y  (y_sl),
      .ci (carry),
      .s  (s_sl),
      .co (co_sl)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         a_r          <= '0;
         b_r          <= '0;
         acc          <= '0;
         carry        <= 1'b0;
         cnt          <= '0;
         ready        <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
         sum          <= '0;
         cout         <= 1'b0;
         ovf          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_r          <= a;
                  b_r          <= b_eff;
                  carry        <= cin_eff;
                  cnt          <= '0;
                  result_valid <= 1'b0;
                  ready        <= 1'b0;
                  busy         <= 1'b1;
                  state        <= S_RUN;
               end
            end
            S_RUN: begin
               acc[lo +: SLICE] <= s_sl;
               carry            <= co_sl;
               cnt              <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               // Overflow: like-signed operands producing an opposite-signed sum.
               sum          <= {carry, acc};
               cout         <= carry;
               ovf          <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (acc[WIDTH-1] != a_r[WIDTH-1]);
               done         <= 1'b1;
               result_valid <= 1'b1;
               ready        <= 1'b1;
               state        <= S_IDLE;
            end
            default: begin
               ready <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_slice_adder.sv
// Scoreboard bench driving three serial_slice_adder builds (SLICE=1,2,4) in lockstep.
// Subtraction vectors are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_slice_adder;

   typedef struct {
      logic [4:0] sum;
      logic       ovf;
      int         acc_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] a, b;
   logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub;
`endif

   logic       rdy [3];
   logic       bsy [3];
   logic       dn  [3];
   logic       rv  [3];
   logic       co  [3];
   logic       ov  [3];
   logic [4:0] sm  [3];

   int         nsl [3] = '{4, 2, 1};
   exp_t       sb  [3][$];
   int         cyc = 0;
   int         checks = 0;
   int         fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_slice_adder #(.WIDTH(4), .SLICE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .result_valid(rv[0]),
      .sum(sm[0]), .cout(co[0]), .ovf(ov[0]));

   serial_slice_adder #(.WIDTH(4), .SLICE(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .result_valid(rv[1]),
      .sum(sm[1]), .cout(co[1]), .ovf(ov[1]));

   serial_slice_adder #(.WIDTH(4), .SLICE(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .result_valid(rv[2]),
      .sum(sm[2]), .cout(co[2]), .ovf(ov[2]));

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d actual=%0h expected=%0h (cycle %0d)", nm, d, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         if (dn[d] === 1'b1) begin
            if (sb[d].size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_done dut%0d actual=done(sum=%0h) expected=no_done", d, sm[d]);
            end else begin
               e = sb[d].pop_front();
               chk("sum", d, 32'(sm[d]), 32'(e.sum));
               chk("cout", d, 32'(co[d]), 32'(e.sum[4]));
               chk("ovf", d, 32'(ov[d]), 32'(e.ovf));
               chk("result_valid", d, 32'(rv[d]), 32'd1);
               chk("latency", d, 32'(cyc - e.acc_cyc), 32'(nsl[d] + 1));
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!(rdy[0] && rdy[1] && rdy[2]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         fails++;
         $display("FAIL ready_timeout actual=not_ready expected=ready within 100 cycles");
      end
   endtask

   // Issue one operation; the expected result travels to the monitor via the scoreboard.
   task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                        input logic is, input logic [4:0] esum, input logic eovf);
      exp_t e;
      wait_idle();
      a     = ia;
      b     = ib;
      cin   = ic;
`ifdef SERIAL_ADDER_SUB_EN
      sub   = is;
`endif
      start = 1'b1;
      @(posedge clk);
      #1;
      e.sum     = esum;
      e.ovf     = eovf;
      e.acc_cyc = cyc;
      for (int d = 0; d < 3; d++) sb[d].push_back(e);
      @(negedge clk);
      start = 1'b0;
      if (is === 1'bx) $display("unreachable");
   endtask

   task automatic issue_model(input logic [3:0] ia, input logic [3:0] ib, input logic ic, input logic is);
      logic [3:0] bb;
      logic       c;
      logic [4:0] s;
      bb = is ? ~ib : ib;
      c  = is ? 1'b1 : ic;
      s  = {1'b0, ia} + {1'b0, bb} + {4'b0, c};
      issue(ia, ib, ic, is, s, (ia[3] == bb[3]) && (s[3] != ia[3]));
   endtask

   initial begin
      int n;
      int submax;
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub    = 1'b0;
      submax = 1;
`else
      submax = 0;
`endif

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_ready", d, 32'(rdy[d]), 32'd1);
         chk("rst_busy", d, 32'(bsy[d]), 32'd0);
         chk("rst_done", d, 32'(dn[d]), 32'd0);
         chk("rst_result_valid", d, 32'(rv[d]), 32'd0);
         chk("rst_sum", d, 32'(sm[d]), 32'd0);
         chk("rst_cout", d, 32'(co[d]), 32'd0);
         chk("rst_ovf", d, 32'(ov[d]), 32'd0);
      end

      // Reset while in RUN: no done, outputs stay cleared
      a = 4'hF; b = 4'h1; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int d = 0; d < 3; d++) chk("run_busy", d, 32'(bsy[d]), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk("abort_ready", d, 32'(rdy[d]), 32'd1);
         chk("abort_busy", d, 32'(bsy[d]), 32'd0);
         chk("abort_sum", d, 32'(sm[d]), 32'd0);
         chk("abort_result_valid", d, 32'(rv[d]), 32'd0);
      end
      repeat (8) @(negedge clk);

      // Directed vectors
      issue(4'hF, 4'h1, 1'b0, 1'b0, 5'h10, 1'b0);
      issue(4'h7, 4'h1, 1'b0, 1'b0, 5'h08, 1'b1);
      issue(4'hF, 4'hF, 1'b1, 1'b0, 5'h1F, 1'b0);
      issue(4'h0, 4'h0, 1'b1, 1'b0, 5'h01, 1'b0);
      issue(4'h8, 4'h8, 1'b0, 1'b0, 5'h10, 1'b1);

      // Start held and operands changed while busy: one result, from the accepted operands
      issue(4'h3, 4'h4, 1'b0, 1'b0, 5'h07, 1'b0);
      a = 4'h9; b = 4'h9; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      a = 4'hE; b = 4'hA;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      for (int d = 0; d < 3; d++) chk("hold_sum", d, 32'(sm[d]), 32'h07);

`ifdef SERIAL_ADDER_SUB_EN
      issue(4'h3, 4'h5, 1'b0, 1'b1, 5'h0E, 1'b0);
      issue(4'h8, 4'h1, 1'b1, 1'b1, 5'h17, 1'b1);
`endif

      // Exhaustive sweep against the reference model
      for (int s = 0; s <= submax; s++)
         for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
               for (int ic = 0; ic < 2; ic++)
                  issue_model(4'(ia), 4'(ib), 1'(ic), 1'(s));

      n = 0;
      while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int d = 0; d < 3; d++) chk("pending_results", d, 32'(sb[d].size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
